// File: rtl/frame_read_ctrl.sv
// Read-side frame fetcher: on each output-frame start, flushes the pixel FIFO and
// streams one frame from the selected DDR bank as FIFO-paced burst reads.
module frame_read_ctrl #(
  parameter int ADDR_W      = 28,
  parameter int BANK_SHIFT  = 23,
  parameter int FRAME_WORDS = 921600,
  parameter int BURST_WORDS = 64,
  parameter int FIFO_DEPTH  = 2048,
  parameter int LVL_W       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vout_vs,
  input  logic [1:0]        rd_bank,
  input  logic [LVL_W-1:0]  fifo_level,
  output logic              rd_cmd_req,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]        rd_cmd_len,
  input  logic              rd_cmd_ack,
  input  logic              rd_data_valid,
  output logic              fifo_clr,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam int OFF_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    CHECK = 3'd2,
    REQ   = 3'd3,
    DATA  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             vs_s0, vs_s1, frame_start;
  logic [1:0]       bank_r;
  logic [OFF_W-1:0] offset, remaining, offset_inc;
  logic [7:0]       len_calc, beat_cnt;
  logic [1:0]       flush_cnt;
  logic             restart_pend;
  logic             fits, last_beat, frame_end, done_nxt;

  assign frame_start = vs_s0 & ~vs_s1;
  assign fifo_clr    = (state == FLUSH);
  assign frame_busy  = (state != IDLE);
  assign dbg_state   = state;

  // Command handshake: rd_cmd_req/addr/len stay stable from assertion until the
  // edge that samples rd_cmd_ack high; the command transfers on that edge and
  // rd_cmd_req drops the following cycle. Only one command is ever outstanding.
  always_comb begin
    remaining  = OFF_W'(FRAME_WORDS) - offset;
    len_calc   = (32'(remaining) >= 32'(BURST_WORDS)) ? 8'(BURST_WORDS) : 8'(remaining);
    fits       = (32'(fifo_level) + 32'(len_calc)) <= 32'(FIFO_DEPTH);
    offset_inc = offset + OFF_W'(rd_cmd_len);
    last_beat  = (state == DATA) && rd_data_valid && ((beat_cnt + 8'd1) == rd_cmd_len);
    frame_end  = (offset_inc == OFF_W'(FRAME_WORDS));
    done_nxt   = 1'b0;
    state_nxt  = state;
    case (state)
      IDLE:  if (frame_start) state_nxt = FLUSH;
      FLUSH: if (!frame_start && flush_cnt == 2'd3) state_nxt = CHECK;
      CHECK: begin
        if (frame_start) state_nxt = FLUSH;
        else if (fits)   state_nxt = REQ;
      end
      REQ:   if (rd_cmd_ack) state_nxt = DATA;
      DATA: begin
        if (last_beat) begin
          // A frame start seen during the burst wins over both CHECK and frame_done.
          if (restart_pend || frame_start) begin
            state_nxt = FLUSH;
          end else if (frame_end) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = CHECK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s0        <= 1'b0;
      vs_s1        <= 1'b0;
      bank_r       <= 2'd0;
      offset       <= '0;
      beat_cnt     <= 8'd0;
      flush_cnt    <= 2'd0;
      restart_pend <= 1'b0;
      rd_cmd_req   <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_len   <= 8'd0;
      frame_done   <= 1'b0;
    end else begin
      vs_s0      <= vout_vs;
      vs_s1      <= vs_s0;
      frame_done <= done_nxt;
      rd_cmd_req <= (state_nxt == REQ);

      if (frame_start) bank_r <= rd_bank;

      if (state == CHECK && state_nxt == REQ) begin
        rd_cmd_addr <= (ADDR_W'(bank_r) << BANK_SHIFT) + ADDR_W'(offset);
        rd_cmd_len  <= len_calc;
      end

      if (state == REQ && rd_cmd_ack)          beat_cnt <= 8'd0;
      else if (state == DATA && rd_data_valid) beat_cnt <= beat_cnt + 8'd1;

      if (state_nxt == FLUSH) offset <= '0;
      else if (last_beat)     offset <= offset_inc;

      if (state_nxt == FLUSH && (state != FLUSH || frame_start)) flush_cnt <= 2'd0;
      else if (state == FLUSH)                                   flush_cnt <= flush_cnt + 2'd1;

      if (state_nxt == FLUSH)                                   restart_pend <= 1'b0;
      else if (frame_start && (state == REQ || state == DATA))  restart_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_read_ctrl.sv
// Self-checking bench for frame_read_ctrl: directed scenarios plus randomized
// frames, checked every cycle against a behavioural model of the fetch rules.
module tb_frame_read_ctrl;
  localparam int ADDR_W = 28, BANK_SHIFT = 20, FRAME_WORDS = 200;
  localparam int BURST_WORDS = 64, FIFO_DEPTH = 2048, LVL_W = 12;

  logic              clk = 1'b0, rst_n = 1'b0, vout_vs = 1'b0;
  logic [1:0]        rd_bank = 2'd0;
  logic [LVL_W-1:0]  fifo_level = '0;
  logic              rd_cmd_ack = 1'b0, rd_data_valid = 1'b0;
  logic              rd_cmd_req, fifo_clr, frame_busy, frame_done;
  logic [ADDR_W-1:0] rd_cmd_addr;
  logic [7:0]        rd_cmd_len;
  logic [2:0]        dbg_state;

  int checks = 0, failures = 0;
  int accepts = 0, done_cnt = 0, clr_cnt = 0, req_hi_cnt = 0;
  logic [ADDR_W+7:0] exp_q[$];

  // responder knobs and state
  int ack_wait = 1, dv_pct = 100, spur_pct = 0, pend = 0, wait_cnt = 0, acked_len = 0;
  bit lvl_rand = 1'b0;
  logic [LVL_W-1:0] lvl_fixed = '0;

  // behavioural model
  bit m_q0, m_q1, m_cmd, m_burst, m_check, m_restart, m_active, m_done;
  int m_flush, m_beats, m_off, m_len;
  logic [1:0] m_bank;
  logic [ADDR_W-1:0] m_addr;

  frame_read_ctrl #(
    .ADDR_W(ADDR_W), .BANK_SHIFT(BANK_SHIFT), .FRAME_WORDS(FRAME_WORDS),
    .BURST_WORDS(BURST_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vout_vs(vout_vs), .rd_bank(rd_bank),
    .fifo_level(fifo_level), .rd_cmd_req(rd_cmd_req), .rd_cmd_addr(rd_cmd_addr),
    .rd_cmd_len(rd_cmd_len), .rd_cmd_ack(rd_cmd_ack), .rd_data_valid(rd_data_valid),
    .fifo_clr(fifo_clr), .frame_busy(frame_busy), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q0 = 0; m_q1 = 0; m_cmd = 0; m_burst = 0; m_check = 0; m_restart = 0;
    m_active = 0; m_done = 0; m_flush = 0; m_beats = 0; m_off = 0; m_len = 0;
    m_bank = 2'd0; m_addr = '0;
  endtask

  task automatic start_flush();
    m_flush = 4; m_off = 0; m_restart = 0; m_check = 0;
  endtask

  // Advance the model across one clock edge using the inputs that edge samples.
  task automatic model_step();
    bit fs;
    int len;
    fs = m_q0 & ~m_q1;
    m_q1 = m_q0;
    m_q0 = vout_vs;
    m_done = 0;
    if (m_burst) begin
      if (rd_data_valid) m_beats--;
      if (m_beats == 0) begin
        m_burst = 0;
        if (m_restart || fs) start_flush();
        else begin
          m_off += m_len;
          if (m_off == FRAME_WORDS) begin m_active = 0; m_done = 1; end
          else m_check = 1;
        end
      end else if (fs) m_restart = 1;
    end else if (m_cmd) begin
      if (fs) m_restart = 1;
      if (rd_cmd_ack) begin m_cmd = 0; m_burst = 1; m_beats = m_len; end
    end else if (m_flush > 0) begin
      if (fs) start_flush();
      else begin
        m_flush--;
        if (m_flush == 0) m_check = 1;
      end
    end else if (m_check) begin
      if (fs) start_flush();
      else begin
        len = (FRAME_WORDS - m_off < BURST_WORDS) ? FRAME_WORDS - m_off : BURST_WORDS;
        if (int'(fifo_level) + len <= FIFO_DEPTH) begin
          m_check = 0; m_cmd = 1; m_len = len;
          m_addr = (ADDR_W'(m_bank) << BANK_SHIFT) + ADDR_W'(m_off);
        end
      end
    end else if (fs) begin
      start_flush();
      m_active = 1;
    end
    if (fs) m_bank = rd_bank;
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else begin
      chk("req", rd_cmd_req, m_cmd);
      if (m_cmd) begin
        chk("addr", rd_cmd_addr, m_addr);
        chk("len", rd_cmd_len, 64'(m_len));
      end
      chk("fifo_clr", fifo_clr, m_flush > 0);
      chk("busy", frame_busy, m_active);
      chk("done", frame_done, m_done);
      if (fifo_clr) clr_cnt++;
      if (frame_done) done_cnt++;
      if (rd_cmd_req) req_hi_cnt++;
      if (rd_cmd_req && rd_cmd_ack) begin
        accepts++;
        if (exp_q.size() > 0) chk("cmd_sb", {rd_cmd_addr, rd_cmd_len}, exp_q.pop_front());
      end
      model_step();
    end
  end

  // DDR port / FIFO level driver
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      rd_cmd_ack = 0; rd_data_valid = 0; pend = 0; wait_cnt = 0;
    end else begin
      if (rd_cmd_ack) begin
        pend += acked_len;
        rd_cmd_ack = 0;
      end else if (rd_cmd_req) begin
        if (wait_cnt >= ack_wait) begin
          rd_cmd_ack = 1; acked_len = int'(rd_cmd_len); wait_cnt = 0;
        end else wait_cnt++;
      end
      if (pend > 0) begin
        rd_data_valid = ($urandom_range(0, 99) < dv_pct);
        if (rd_data_valid) pend--;
      end else begin
        rd_data_valid = (spur_pct > 0) && ($urandom_range(0, 99) < spur_pct);
      end
    end
    if (lvl_rand)
      fifo_level = ($urandom_range(0, 3) == 0) ? LVL_W'($urandom_range(1985, 2048))
                                               : LVL_W'($urandom_range(0, 1984));
    else
      fifo_level = lvl_fixed;
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic obs();  @(negedge clk); #1; endtask

  task automatic pulse_vs(input logic [1:0] bank);
    tick(); rd_bank = bank; vout_vs = 1;
    repeat (4) tick();
    vout_vs = 0;
  endtask

  task automatic push_cmd(input int addr, input int len);
    exp_q.push_back({ADDR_W'(addr), 8'(len)});
  endtask

  task automatic wait_done(input int target, input int bound, input string nm);
    int n = 0;
    while (done_cnt < target && n < bound) begin obs(); n++; end
    chk(nm, done_cnt >= target, 1);
  endtask

  initial begin
    int d0, a0, c0, r0, lat, hi, n;
    // 1: reset values, no activity without frame start
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req", rd_cmd_req, 0);   chk("rst_addr", rd_cmd_addr, 0);
    chk("rst_len", rd_cmd_len, 0);   chk("rst_clr", fifo_clr, 0);
    chk("rst_busy", frame_busy, 0);  chk("rst_done", frame_done, 0);
    chk("rst_state", dbg_state, 0);
    tick(); rst_n = 1;
    r0 = req_hi_cnt;
    repeat (100) obs();
    chk("idle_no_req", req_hi_cnt - r0, 0);

    // 2: full frame from bank 2, latency and command list
    ack_wait = 1; dv_pct = 100; lvl_fixed = 0;
    push_cmd('h200000, 64); push_cmd('h200040, 64); push_cmd('h200080, 64); push_cmd('h2000C0, 8);
    c0 = clr_cnt; d0 = done_cnt; lat = -1;
    tick(); rd_bank = 2; vout_vs = 1;
    for (int i = 0; i < 20; i++) begin
      obs();
      if (rd_cmd_req && lat < 0) lat = i;
    end
    chk("fs_latency", lat, 7);
    tick(); vout_vs = 0;
    wait_done(d0 + 1, 2000, "t2_done_timeout");
    repeat (3) obs();
    chk("t2_flush_cycles", clr_cnt - c0, 4);
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk("t2_busy_after", frame_busy, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // 3: long ack stall keeps the command stable, one acceptance
    ack_wait = 20;
    push_cmd('h300000, 64); push_cmd('h300040, 64); push_cmd('h300080, 64); push_cmd('h3000C0, 8);
    d0 = done_cnt;
    pulse_vs(3);
    n = 0;
    while (!rd_cmd_req && n < 50) begin obs(); n++; end
    a0 = accepts; hi = 0;
    while (rd_cmd_req && hi < 100) begin hi++; obs(); end
    chk("t3_req_hold", hi, 21);
    chk("t3_one_accept", accepts - a0, 1);
    wait_done(d0 + 1, 3000, "t3_done_timeout");
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: FIFO space gating
    ack_wait = 0; lvl_fixed = LVL_W'(FIFO_DEPTH - 63);
    push_cmd('h000000, 64);
    d0 = done_cnt; a0 = accepts;
    pulse_vs(0);
    repeat (30) obs();
    chk("t4_blocked_req", rd_cmd_req, 0);
    chk("t4_blocked_acc", accepts - a0, 0);
    tick(); lvl_fixed = LVL_W'(FIFO_DEPTH - 64);
    obs(); chk("t4_req_1cyc", rd_cmd_req, 0);
    obs(); chk("t4_req_2cyc", rd_cmd_req, 1);
    tick(); lvl_fixed = 0;
    wait_done(d0 + 1, 2000, "t4_done_timeout");

    // 5: frame restart during the second burst's data phase
    ack_wait = 1; dv_pct = 50;
    push_cmd('h000000, 64); push_cmd('h000040, 64);
    push_cmd('h100000, 64); push_cmd('h100040, 64); push_cmd('h100080, 64); push_cmd('h1000C0, 8);
    d0 = done_cnt; a0 = accepts;
    pulse_vs(0);
    n = 0;
    while (accepts < a0 + 2 && n < 1000) begin obs(); n++; end
    chk("t5_two_bursts", accepts - a0, 2);
    c0 = clr_cnt;
    pulse_vs(1);
    n = 0;
    while (accepts < a0 + 3 && n < 1000) begin obs(); n++; end
    chk("t5_third_cmd", accepts - a0, 3);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_flush_cycles", clr_cnt - c0, 4);
    wait_done(d0 + 1, 3000, "t5_done_timeout");
    chk("t5_sb_empty", exp_q.size(), 0);

    // 6: asynchronous reset in the middle of a request
    ack_wait = 50; dv_pct = 100;
    pulse_vs(1);
    n = 0;
    while (!rd_cmd_req && n < 50) begin obs(); n++; end
    chk("t6_req_seen", rd_cmd_req, 1);
    @(posedge clk); #3; rst_n = 0; #1;
    chk("t6_req", rd_cmd_req, 0);   chk("t6_addr", rd_cmd_addr, 0);
    chk("t6_len", rd_cmd_len, 0);   chk("t6_busy", frame_busy, 0);
    chk("t6_clr", fifo_clr, 0);     chk("t6_done", frame_done, 0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1;
    r0 = req_hi_cnt;
    repeat (60) obs();
    chk("t6_quiet", req_hi_cnt - r0, 0);
    chk("t6_idle", frame_busy, 0);

    // randomized frames, restarts, stalls, spurious beats and FIFO pressure
    lvl_rand = 1; spur_pct = 20;
    for (int f = 0; f < 12; f++) begin
      ack_wait = $urandom_range(0, 4);
      dv_pct = $urandom_range(30, 100);
      pulse_vs(2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 250)) tick();
        pulse_vs(2'($urandom_range(0, 3)));
      end
      n = 0;
      while (frame_busy && n < 6000) begin obs(); n++; end
      chk("rand_frame_end", frame_busy, 0);
    end
    lvl_rand = 0; spur_pct = 0;
    repeat (5) obs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_read_ctrl.md
# frame_read_ctrl

Read-side frame fetcher for the DDR triple-buffer video path. On each output-frame start it latches the bank selected by the bank switcher. It then issues sequential burst-read commands for that bank to the DDR port, paced by free space in the downstream read-data FIFO, until the whole frame has been requested and returned. It sits between the bank switcher (`rd_bank`), the DDR read command/data port and the output-side pixel FIFO.

## Interface
Parameters:
- ADDR_W, 28: DDR word-address width.
- BANK_SHIFT, 23: bank base address = rd_bank << BANK_SHIFT.
- FRAME_WORDS, 921600: words per frame (1280x720).
- BURST_WORDS, 64: maximum words per read command.
- FIFO_DEPTH, 2048: read-data FIFO capacity in words.
- LVL_W, 12: width of fifo_level.

Ports:
- clk  in  1  system/DDR-user clock.
- rst_n  in  1  reset; asynchronous, active-low.
- vout_vs  in  1  output vsync, asynchronous to clk; a rising edge marks frame start.
- rd_bank  in  2  bank to read, sampled at frame start.
- fifo_level  in  LVL_W  words currently held in the read-data FIFO.
- rd_cmd_req  out  1  read command valid.
- rd_cmd_addr  out  ADDR_W  burst start word address.
- rd_cmd_len  out  8  burst length in words (1..BURST_WORDS).
- rd_cmd_ack  in  1  command accepted this cycle.
- rd_data_valid  in  1  one returned word this cycle; the word goes directly to the FIFO.
- fifo_clr  out  1  FIFO flush.
- frame_busy  out  1  a frame fetch is in progress.
- frame_done  out  1  one-cycle pulse when the last word of a frame has returned.

## Operation
- vout_vs passes through a 2-flop synchronizer (s0, s1). A frame start is s0 & ~s1.
- States:
  - IDLE
  - FLUSH: 4 cycles; fifo_clr=1.
  - CHECK
  - REQ: rd_cmd_req=1.
  - DATA: counting returned words.
- On frame start: latch the bank, set the word offset to 0 and clear beat counters.
  - In IDLE or CHECK: go to FLUSH immediately.
  - In REQ or DATA: set restart_pend. The in-flight command must still complete and its data be drained. When DATA completes, go to FLUSH instead of CHECK, and clear restart_pend.
  - A frame start during FLUSH restarts the FLUSH count and re-latches the bank.
- CHECK:
  - remaining = FRAME_WORDS - offset.
  - len = min(BURST_WORDS, remaining).
  - If fifo_level + len <= FIFO_DEPTH, go to REQ with rd_cmd_addr = (bank << BANK_SHIFT) + offset and rd_cmd_len = len. Otherwise stay in CHECK.
- REQ: rd_cmd_req, rd_cmd_addr and rd_cmd_len are held stable until rd_cmd_ack. The request is never withdrawn, including on restart. On ack, go to DATA.
- DATA: count rd_data_valid beats. When the count reaches len:
  - offset += len.
  - If offset == FRAME_WORDS: frame_done pulses and the block goes to IDLE.
  - Otherwise go to CHECK.
- Only one command is outstanding at a time.
- rd_data_valid outside DATA is ignored and not counted.
- Address arithmetic is modulo 2^ADDR_W. The offset counter is wide enough for FRAME_WORDS.
- frame_busy=1 in every state except IDLE.

## Timing
- Reset values: rd_cmd_req=0, rd_cmd_addr=0, rd_cmd_len=0, fifo_clr=0, frame_busy=0, frame_done=0. State is IDLE, latched bank 0, synchronizer flops 0.
- Frame-start latency:
  - vout_vs is sampled high at clk edge k.
  - The frame start is detected at edge k+1.
  - FLUSH covers cycles k+2..k+5 with fifo_clr=1.
  - CHECK is at k+6.
  - The earliest rd_cmd_req is at k+7.
- rd_cmd_req is registered; it drops in the cycle after the ack edge.
- frame_done is asserted in the cycle after the edge that samples the final rd_data_valid.

## Test plan
1. Reset with vout_vs=0 -> all outputs 0 and state IDLE. Hold for 100 cycles with no frame start -> no rd_cmd_req.
2. FRAME_WORDS=200, BURST_WORDS=64, BANK_SHIFT=20, rd_bank=2, fifo_level=0, ack after 1 cycle, data returned back-to-back:
   - fifo_clr is high for exactly 4 cycles.
   - Commands are addr 0x200000/64, 0x200040/64, 0x200080/64, 0x2000C0/8.
   - frame_done is a single pulse and frame_busy falls afterwards.
3. Hold rd_cmd_ack low for 20 cycles -> rd_cmd_req, addr and len are stable throughout; exactly one command is accepted.
4. fifo_level = FIFO_DEPTH-63 with len=64 -> no request. Drop fifo_level to FIFO_DEPTH-64 -> rd_cmd_req asserts 2 cycles later.
5. Frame start with rd_bank=1 during DATA of the 2nd burst:
   - The remaining beats of that burst are consumed.
   - FLUSH follows with no frame_done.
   - The next command is addr 0x100000, len 64.
6. rst_n asserted mid-REQ -> outputs return to reset values immediately (asynchronously). After release, nothing is issued until a new vout_vs rising edge.
